oserdes_ddr: RTL and testbench

OSERDES_DDR -- requirements
Module: oserdes_ddr

---
 rtl/oserdes_ddr_pkg.sv | 19 +
 rtl/ddr_out_cell.sv | 34 +++
 rtl/oserdes_ddr.sv | 143 ++++++++++++++
 tb/tb_oserdes_ddr.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oserdes_ddr_pkg.sv
// rtl/oserdes_ddr_pkg.sv - parameter legality checks and counter width helpers for oserdes_ddr
package oserdes_ddr_pkg;

    // Width of the pair counter: holds 0..dw/2-1, never narrower than one bit.
    function automatic int pair_cnt_w(input int dw);
        return (dw / 2 < 2) ? 1 : $clog2(dw / 2);
    endfunction

    // Width of the bit-slip counter: holds 0..dw-1, never narrower than one bit.
    function automatic int slip_cnt_w(input int dw);
        return (dw < 2) ? 1 : $clog2(dw);
    endfunction

    // Word width must be even and 2..16; lane count 1..16.
    function automatic bit params_legal(input int dw, input int ch);
        return (dw % 2 == 0) && (dw >= 2) && (dw <= 16) && (ch >= 1) && (ch <= 16);
    endfunction

endpackage

// File: rtl/ddr_out_cell.sv
// rtl/ddr_out_cell.sv - one DDR output lane: posedge pair register, negedge odd stage, clock-selected Q
module ddr_out_cell #(
    parameter logic INIT = 1'b0
) (
    input  logic c_i,
    input  logic rst_i,
    input  logic even_i,
    input  logic odd_i,
    output logic q_o
);

    logic pos_even_q;
    logic pos_odd_q;
    logic neg_odd_q;

    // Capture the next pair on posedge; reset parks both bits at the idle level.
    always_ff @(posedge c_i) begin
        if (rst_i) begin
            pos_even_q <= INIT;
            pos_odd_q  <= INIT;
        end else begin
            pos_even_q <= even_i;
            pos_odd_q  <= odd_i;
        end
    end

    // Retime the odd bit so it is stable for the whole low half of the clock.
    always_ff @(negedge c_i) begin
        neg_odd_q <= pos_odd_q;
    end

    assign q_o = c_i ? pos_even_q : neg_odd_q;

endmodule

// File: rtl/oserdes_ddr.sv
// rtl/oserdes_ddr.sv - multi-lane DDR serializer; OSERDES_DDR_BITSLIP_EN adds the BITSLIP rotation input
module oserdes_ddr
    import oserdes_ddr_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter int   CHANNELS   = 1,
    parameter logic INIT       = 1'b0,
    parameter int   LSB_FIRST  = 1
) (
    input  logic                           C,
    input  logic                           R,
    input  logic                           S_VALID,
    output logic                           S_READY,
    input  logic [CHANNELS*DATA_WIDTH-1:0] S_DATA,
    output logic [CHANNELS-1:0]            Q,
    output logic                           UNDERRUN
`ifdef OSERDES_DDR_BITSLIP_EN
    ,
    input  logic                           BITSLIP
`endif
);

    localparam int                  PAIRS     = DATA_WIDTH / 2;
    localparam int                  CW        = pair_cnt_w(DATA_WIDTH);
    localparam logic [CW-1:0]       LAST_PAIR = CW'(PAIRS - 1);

    if (!params_legal(DATA_WIDTH, CHANNELS)) begin : g_bad_params
        $error("oserdes_ddr: DATA_WIDTH must be even 2..16 and CHANNELS 1..16");
    end

    logic [CHANNELS-1:0][DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0]               lane_w;
    logic [DATA_WIDTH-1:0]               seq_w;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic                                busy_q, busy_d;   // shift register still holds unsent pairs
    logic                                emit_q, emit_d;   // output cells currently carry word data
    logic                                underrun_q, underrun_d;
    logic                                rdy_en_q;         // low for the reset cycles, high afterwards
    logic [CHANNELS-1:0]                 even_w, odd_w;
    logic                                accept;

`ifdef OSERDES_DDR_BITSLIP_EN
    localparam int                       SW = slip_cnt_w(DATA_WIDTH);
    logic [SW-1:0]                       slip_q;
    logic [2*DATA_WIDTH-1:0]             dbl_w;
`endif

    assign S_READY  = rdy_en_q & (~busy_q | (cnt_q == LAST_PAIR));
    assign accept   = S_VALID & S_READY;
    assign UNDERRUN = underrun_q;

    // Reorder each lane into emission order (bit 0 goes first) and apply the slip rotation.
    always_comb begin
        load_word = '0;
        lane_w    = '0;
        seq_w     = '0;
`ifdef OSERDES_DDR_BITSLIP_EN
        dbl_w     = '0;
`endif
        for (int l = 0; l < CHANNELS; l++) begin
            lane_w = S_DATA[l*DATA_WIDTH +: DATA_WIDTH];
            seq_w  = (LSB_FIRST != 0) ? lane_w : {<<{lane_w}};
`ifdef OSERDES_DDR_BITSLIP_EN
            dbl_w        = {seq_w, seq_w} << slip_q;
            load_word[l] = dbl_w[2*DATA_WIDTH-1 -: DATA_WIDTH];
`else
            load_word[l] = seq_w;
`endif
        end
    end

    // Pair sequencing: shift out two bits per cycle, reload on handshake, flag a dry word boundary.
    always_comb begin
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        emit_d     = busy_q;
        underrun_d = underrun_q | (emit_q & ~busy_q);
        even_w     = {CHANNELS{INIT}};
        odd_w      = {CHANNELS{INIT}};
        if (busy_q) begin
            for (int l = 0; l < CHANNELS; l++) begin
                even_w[l] = sh_q[l][0];
                odd_w[l]  = sh_q[l][1];
                sh_d[l]   = sh_q[l] >> 2;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_PAIR) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
        if (accept) begin
            sh_d   = load_word;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    // Sequencer state register with synchronous reset that drops any word in flight.
    always_ff @(posedge C) begin
        if (R) begin
            sh_q       <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            emit_q     <= 1'b0;
            underrun_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            emit_q     <= emit_d;
            underrun_q <= underrun_d;
            rdy_en_q   <= 1'b1;
        end
    end

`ifdef OSERDES_DDR_BITSLIP_EN
    // Slip count advances once per BITSLIP cycle and wraps at the word width.
    always_ff @(posedge C) begin
        if (R) begin
            slip_q <= '0;
        end else if (BITSLIP) begin
            slip_q <= (slip_q == SW'(DATA_WIDTH - 1)) ? '0 : slip_q + 1'b1;
        end
    end
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        ddr_out_cell #(
            .INIT (INIT)
        ) u_cell (
            .c_i    (C),
            .rst_i  (R),
            .even_i (even_w[g]),
            .odd_i  (odd_w[g]),
            .q_o    (Q[g])
        );
    end

endmodule

// File: tb/tb_oserdes_ddr.sv
// tb/tb_oserdes_ddr.sv - self-checking bench for oserdes_ddr against a half-bit timeline model
module tb_oserdes_ddr;

    localparam int TMAX = 4096;

    logic        c = 1'b0;
    logic        r = 1'b1;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic [15:0] d0 = '0;
    logic [3:0]  d1 = '0;
    logic        bs0 = 1'b0;
    logic        bs1 = 1'b0;
    logic        rdy0, rdy1, und0, und1;
    logic [1:0]  q0;
    logic [0:0]  q1;

    always #5 c = ~c;

    oserdes_ddr #(.DATA_WIDTH(8), .CHANNELS(2), .INIT(1'b0), .LSB_FIRST(1)) dut0 (
        .C(c), .R(r), .S_VALID(v0), .S_READY(rdy0), .S_DATA(d0), .Q(q0), .UNDERRUN(und0)
`ifdef OSERDES_DDR_BITSLIP_EN
        , .BITSLIP(bs0)
`endif
    );

    oserdes_ddr #(.DATA_WIDTH(4), .CHANNELS(1), .INIT(1'b1), .LSB_FIRST(0)) dut1 (
        .C(c), .R(r), .S_VALID(v1), .S_READY(rdy1), .S_DATA(d1), .Q(q1), .UNDERRUN(und1)
`ifdef OSERDES_DDR_BITSLIP_EN
        , .BITSLIP(bs1)
`endif
    );

    // Timeline model: for each posedge index, whether a word owns it and the two half-bits per lane.
    bit   own [2][TMAX];
    bit   eb  [2][TMAX][2][2];
    int   last_pe [2];
    int   slip_m  [2];
    bit   rdy_m   [2];
    bit   und_m   [2];
    int   t = -1;
    int   tests = 0;
    int   fails = 0;
    logic [1:0] ob_hi0, ob_lo0;
    logic       ob_hi1, ob_lo1;

    task automatic model_edge(input int i, input bit vin, input logic [15:0] w, input bit bs);
        int  dw;
        int  ch;
        bit  lsb;
        int  pos;
        bit  b;
        dw  = (i == 0) ? 8 : 4;
        ch  = (i == 0) ? 2 : 1;
        lsb = (i == 0);
        if (r) begin
            for (int tt = t; tt < TMAX; tt++) own[i][tt] = 1'b0;
            last_pe[i] = -1;
            slip_m[i]  = 0;
            rdy_m[i]   = 1'b0;
            und_m[i]   = 1'b0;
            return;
        end
        if (t > 0 && own[i][t-1] && !own[i][t]) und_m[i] = 1'b1;
        if (vin && rdy_m[i]) begin
            for (int l = 0; l < ch; l++) begin
                for (int p = 0; p < dw; p++) begin
                    b   = lsb ? w[l*dw + p] : w[l*dw + dw - 1 - p];
                    pos = (p + slip_m[i]) % dw;
                    eb[i][t + 1 + pos/2][l][pos % 2] = b;
                end
            end
            for (int k = 1; k <= dw/2; k++) own[i][t+k] = 1'b1;
            last_pe[i] = t + dw/2;
        end
        if (bs) slip_m[i] = (slip_m[i] + 1) % dw;
        rdy_m[i] = (last_pe[i] <= t + 1);
    endtask

    // One clock: advance the model at posedge, compare the high half, then the low half.
    task automatic cycle();
        logic e;
        @(posedge c);
        t++;
        model_edge(0, v0, d0, bs0);
        model_edge(1, v1, {12'b0, d1}, bs1);
        #2;
        tests++;
        if (rdy0 !== rdy_m[0]) begin fails++; $display("FAIL rdy0 t=%0d: got %b expected %b", t, rdy0, rdy_m[0]); end
        tests++;
        if (rdy1 !== rdy_m[1]) begin fails++; $display("FAIL rdy1 t=%0d: got %b expected %b", t, rdy1, rdy_m[1]); end
        tests++;
        if (und0 !== und_m[0]) begin fails++; $display("FAIL und0 t=%0d: got %b expected %b", t, und0, und_m[0]); end
        tests++;
        if (und1 !== und_m[1]) begin fails++; $display("FAIL und1 t=%0d: got %b expected %b", t, und1, und_m[1]); end
        for (int l = 0; l < 2; l++) begin
            e = own[0][t] ? eb[0][t][l][0] : 1'b0;
            tests++;
            if (q0[l] !== e) begin fails++; $display("FAIL q0_hi lane%0d t=%0d: got %b expected %b", l, t, q0[l], e); end
        end
        e = own[1][t] ? eb[1][t][0][0] : 1'b1;
        tests++;
        if (q1[0] !== e) begin fails++; $display("FAIL q1_hi t=%0d: got %b expected %b", t, q1[0], e); end
        ob_hi0 = q0;
        ob_hi1 = q1[0];
        @(negedge c);
        #2;
        for (int l = 0; l < 2; l++) begin
            e = own[0][t] ? eb[0][t][l][1] : 1'b0;
            tests++;
            if (q0[l] !== e) begin fails++; $display("FAIL q0_lo lane%0d t=%0d: got %b expected %b", l, t, q0[l], e); end
        end
        e = own[1][t] ? eb[1][t][0][1] : 1'b1;
        tests++;
        if (q1[0] !== e) begin fails++; $display("FAIL q1_lo t=%0d: got %b expected %b", t, q1[0], e); end
        ob_lo0 = q0;
        ob_lo1 = q1[0];
    endtask

    task automatic do_reset();
        v0 = 1'b0; v1 = 1'b0; bs0 = 1'b0; bs1 = 1'b0;
        r = 1'b1;
        cycle();
        r = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        r = 1'b1; v0 = 1'b0; v1 = 1'b0;
        repeat (3) cycle();
        tests++;
        if (rdy0 !== 1'b0 || und0 !== 1'b0) begin fails++; $display("FAIL reset_flags: got rdy=%b und=%b expected 0 0", rdy0, und0); end
        tests++;
        if (ob_hi0 !== 2'b00 || ob_lo0 !== 2'b00) begin fails++; $display("FAIL reset_q0: got %b/%b expected 00/00", ob_hi0, ob_lo0); end
        tests++;
        if (ob_hi1 !== 1'b1 || ob_lo1 !== 1'b1) begin fails++; $display("FAIL reset_q1: got %b/%b expected 1/1", ob_hi1, ob_lo1); end
        r = 1'b0;
        cycle();
        tests++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b %b expected 1 1", rdy0, rdy1); end
    endtask

    task automatic test_single_word();
        logic [7:0] s;
        do_reset();
        s = '0;
        v0 = 1'b1; d0 = {8'($urandom), 8'hA5};
        cycle();
        v0 = 1'b0; d0 = 16'($urandom);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            s = {s[5:0], ob_hi0[0], ob_lo0[0]};
            if (k == 2) begin
                tests++;
                if (rdy0 !== 1'b0) begin fails++; $display("FAIL ready_mid_word: got %b expected 0", rdy0); end
            end
            if (k == 3) begin
                tests++;
                if (rdy0 !== 1'b1) begin fails++; $display("FAIL ready_last_pair: got %b expected 1", rdy0); end
            end
        end
        tests++;
        if (s !== 8'b10100101) begin fails++; $display("FAIL a5_stream: got %b expected 10100101", s); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        do_reset();
        s = '0;
        v0 = 1'b1; d0 = {8'($urandom), 8'h0F};
        cycle();
        for (int k = 1; k <= 8; k++) begin
            if (k < 4)       begin v0 = 1'b1; d0 = 16'($urandom); end
            else if (k == 4) begin v0 = 1'b1; d0 = {8'($urandom), 8'hF0}; end
            else             begin v0 = 1'b0; d0 = 16'($urandom); end
            cycle();
            s = {s[13:0], ob_hi0[0], ob_lo0[0]};
        end
        tests++;
        if (s !== 16'b1111000000001111) begin fails++; $display("FAIL b2b_stream: got %b expected 1111000000001111", s); end
        tests++;
        if (und0 !== 1'b0) begin fails++; $display("FAIL b2b_underrun: got %b expected 0", und0); end
    endtask

    task automatic test_underrun();
        do_reset();
        v0 = 1'b1; d0 = {8'($urandom), 8'hFF};
        cycle();
        v0 = 1'b0;
        repeat (4) cycle();
        tests++;
        if (und0 !== 1'b0) begin fails++; $display("FAIL und_early: got %b expected 0", und0); end
        cycle();
        tests++;
        if (ob_hi0[0] !== 1'b0 || ob_lo0[0] !== 1'b0) begin fails++; $display("FAIL idle_q: got %b/%b expected 0/0", ob_hi0[0], ob_lo0[0]); end
        tests++;
        if (und0 !== 1'b1) begin fails++; $display("FAIL und_set: got %b expected 1", und0); end
        repeat (3) cycle();
        tests++;
        if (und0 !== 1'b1) begin fails++; $display("FAIL und_sticky: got %b expected 1", und0); end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        v0 = 1'b1; d0 = 16'hFFFF;
        cycle();
        v0 = 1'b0;
        cycle();
        r = 1'b1;
        cycle();
        tests++;
        if (ob_hi0 !== 2'b00 || ob_lo0 !== 2'b00) begin fails++; $display("FAIL mid_reset_q: got %b/%b expected 00/00", ob_hi0, ob_lo0); end
        tests++;
        if (rdy0 !== 1'b0 || und0 !== 1'b0) begin fails++; $display("FAIL mid_reset_flags: got rdy=%b und=%b expected 0 0", rdy0, und0); end
        r = 1'b0;
        cycle();
        tests++;
        if (rdy0 !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %b expected 1", rdy0); end
        cycle();
        tests++;
        if (und0 !== 1'b0) begin fails++; $display("FAIL mid_reset_und: got %b expected 0", und0); end
    endtask

    task automatic test_msb_first();
        logic [3:0] s;
        do_reset();
        s = '0;
        v1 = 1'b1; d1 = 4'b1000;
        cycle();
        v1 = 1'b0; d1 = 4'($urandom);
        for (int k = 0; k < 2; k++) begin
            cycle();
            s = {s[1:0], ob_hi1, ob_lo1};
        end
        tests++;
        if (s !== 4'b1000) begin fails++; $display("FAIL msb_first: got %b expected 1000", s); end
    endtask

`ifdef OSERDES_DDR_BITSLIP_EN
    task automatic test_bitslip();
        logic [7:0] s;
        for (int n = 1; n <= 8; n += 7) begin
            do_reset();
            s = '0;
            bs0 = 1'b1;
            repeat (n) cycle();
            bs0 = 1'b0;
            v0 = 1'b1; d0 = {8'($urandom), 8'h01};
            cycle();
            v0 = 1'b0;
            for (int k = 0; k < 4; k++) begin
                cycle();
                s = {s[5:0], ob_hi0[0], ob_lo0[0]};
            end
            tests++;
            if (s !== ((n == 1) ? 8'b01000000 : 8'b10000000)) begin
                fails++; $display("FAIL bitslip_%0d: got %b", n, s);
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            d0 = 16'($urandom);
            d1 = 4'($urandom);
            r  = ($urandom_range(0, 99) == 0);
`ifdef OSERDES_DDR_BITSLIP_EN
            bs0 = ($urandom_range(0, 19) == 0);
            bs1 = ($urandom_range(0, 19) == 0);
`endif
            cycle();
        end
        r = 1'b0; v0 = 1'b0; v1 = 1'b0; bs0 = 1'b0; bs1 = 1'b0;
        repeat (6) cycle();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            last_pe[i] = -1; slip_m[i] = 0; rdy_m[i] = 1'b0; und_m[i] = 1'b0;
        end
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_reset_mid_word();
        test_msb_first();
`ifdef OSERDES_DDR_BITSLIP_EN
        test_bitslip();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
